// File: rtl/fetch_pkg.sv
// Shared constants and the fetched-word record for the fetch unit.
// The stall counter is present only when FETCH_STALL_CNT_EN is defined.
package fetch_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 8;
    localparam int WORD_W  = PC_W + INSTR_W;

    localparam logic [PC_W-1:0] RESET_PC = 8'h00;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_word_t;

endpackage

// File: rtl/fetch_skid_slot.sv
// One-entry holding slot for a fetched word the output register could not take.
// A load in the same cycle as a clear wins, so the slot can be drained and refilled at once.
module fetch_skid_slot
    import fetch_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [WORD_W-1:0] d,
    output logic              valid,
    output logic [WORD_W-1:0] q
);

    logic        valid_q, valid_d;
    fetch_word_t entry_q, entry_d;

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (load) begin
            valid_d = 1'b1;
            entry_d = d;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid = valid_q;
    assign q     = entry_q;

endmodule

// File: rtl/fetch_unit.sv
// Program counter, memory request tracking and decode-facing output register of the 8-bit CPU.
// Define FETCH_STALL_CNT_EN to add the saturating stall_count output.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    output logic [PC_W-1:0]    pccounter,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               decode_ready,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]        stall_count
`endif
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            req_valid_q, req_valid_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            out_valid_q, out_valid_d;
    fetch_word_t     out_q, out_d;

    logic        skid_valid;
    logic        skid_load;
    logic        skid_clear;
    logic        skid_valid_next;
    fetch_word_t skid_word;
    fetch_word_t cand_word;
    logic        fire;
    logic        slot_free;
    logic        issue;

    fetch_skid_slot u_skid (
        .clock (clock),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (cand_word),
        .valid (skid_valid),
        .q     (skid_word)
    );

    always_comb begin
        cand_word       = '{pc: req_pc_q, instr: instr_in};
        fire            = out_valid_q & decode_ready;
        slot_free       = !out_valid_q | fire;
        out_valid_d     = out_valid_q;
        out_d           = out_q;
        skid_load       = 1'b0;
        skid_clear      = 1'b0;
        skid_valid_next = skid_valid;
        req_valid_d     = 1'b0;
        req_pc_d        = req_pc_q;
        pc_d            = pc_q;
        issue           = 1'b0;

        if (branch_taken) begin
            out_valid_d     = 1'b0;
            skid_clear      = 1'b1;
            skid_valid_next = 1'b0;
            pc_d            = branch_target;
        end else begin
            if (slot_free) begin
                if (skid_valid) begin
                    // Oldest word leaves the skid; a word returning now takes its place.
                    out_valid_d     = 1'b1;
                    out_d           = skid_word;
                    skid_clear      = !req_valid_q;
                    skid_load       = req_valid_q;
                    skid_valid_next = req_valid_q;
                end else if (req_valid_q) begin
                    out_valid_d = 1'b1;
                    out_d       = cand_word;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (req_valid_q) begin
                skid_load       = 1'b1;
                skid_valid_next = 1'b1;
            end

            // Only request a new word when the skid will be free to catch it.
            issue = !skid_valid_next;
            if (issue) begin
                req_valid_d = 1'b1;
                req_pc_d    = pc_q;
                pc_d        = pc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            req_pc_q    <= req_pc_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign pccounter   = pc_q;
    assign instr_valid = out_valid_q;
    assign instr_out   = out_q.instr;
    assign pc_out      = out_q.pc;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !decode_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    // No stall counter in this build.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: the expected instruction stream is the run of
// consecutive addresses from reset or the last branch target, each word being addr ^ 8'h5A.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_pkg::*;

    logic               clock;
    logic               reset;
    logic [PC_W-1:0]    pccounter;
    logic [INSTR_W-1:0] instr_in;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic               decode_ready;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    pc_out;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0]        stall_count;
`endif

    fetch_unit dut (
        .clock         (clock),
        .reset         (reset),
        .pccounter     (pccounter),
        .instr_in      (instr_in),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .decode_ready  (decode_ready),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .pc_out        (pc_out)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_count   (stall_count)
`endif
    );

    // ---------------- clock / memory ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [INSTR_W-1:0] mem_q;
    always @(posedge clock) mem_q <= pccounter ^ 8'h5A;
    assign instr_in = mem_q;

    // ---------------- scoreboard state ----------------
    logic [15:0]     exp_q[$];
    logic [PC_W-1:0] next_pc;
    logic            flush_pending;
    logic [PC_W-1:0] flush_pc;
    int              n_checks;
    int              n_fail;
    int              n_fired;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic            prev_stall;
    logic [PC_W-1:0] prev_pc;
    logic [7:0]      prev_instr;
    logic [15:0]     exp_word;

    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", instr_valid, 1);
                check("stall_hold_pc", pc_out, prev_pc);
                check("stall_hold_instr", instr_out, prev_instr);
            end
            if (instr_valid && decode_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream_word: got %0h, expected nothing (t=%0t)", {pc_out, instr_out}, $time);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("stream_word", {pc_out, instr_out}, exp_word);
                end
                n_fired++;
            end
            prev_stall = instr_valid && !decode_ready && !branch_taken;
            prev_pc    = pc_out;
            prev_instr = instr_out;
            if (flush_pending) begin
                exp_q.delete();
                next_pc       = flush_pc;
                flush_pending = 1'b0;
            end
            while (exp_q.size() < 4) begin
                exp_q.push_back({next_pc, next_pc ^ 8'h5A});
                next_pc = next_pc + 8'd1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic flush_to(input logic [PC_W-1:0] pc);
        exp_q.delete();
        next_pc       = pc;
        flush_pending = 1'b0;
    endtask

    task automatic branch(input logic [PC_W-1:0] target);
        branch_taken  = 1'b1;
        branch_target = target;
        flush_pending = 1'b1;
        flush_pc      = target;
        tick();
        branch_taken  = 1'b0;
    endtask

    task automatic startup_checks(input string tag);
        check({tag, "_pc0"}, pccounter, 8'h00);
        tick();
        check({tag, "_pc1"}, pccounter, 8'h01);
        check({tag, "_valid_e1"}, instr_valid, 0);
        tick();
        check({tag, "_valid_e2"}, instr_valid, 1);
        check({tag, "_pcout_e2"}, pc_out, 8'h00);
        check({tag, "_instr_e2"}, instr_out, 8'h5A);
        check({tag, "_pc2"}, pccounter, 8'h02);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    logic [PC_W-1:0] pc_start;
    logic [PC_W-1:0] pc_diff;
    int              fired_before;

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        n_fired       = 0;
        reset         = 1'b1;
        decode_ready  = 1'b1;
        branch_taken  = 1'b0;
        branch_target = '0;
        flush_pending = 1'b0;
        flush_pc      = '0;
        prev_stall    = 1'b0;
        flush_to(RESET_PC);
        tick();
        tick();
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr_out, 0);
        check("rst_pcout", pc_out, 0);
        check("rst_pccounter", pccounter, RESET_PC);
        reset = 1'b0;

        // Startup and steady stream.
        startup_checks("start");
        tick();
        check("steady_pc01", pc_out, 8'h01);
        tick();
        check("steady_pc02", pc_out, 8'h02);
        tick();
        check("steady_pc03", pc_out, 8'h03);

        // Stall at pc_out=03 for 5 cycles.
        decode_ready = 1'b0;
        pc_start     = pccounter;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_pcout", pc_out, 8'h03);
            check("stall_instr", instr_out, 8'h59);
        end
        pc_diff = pccounter - pc_start;
        check("stall_pc_stop", (pc_diff <= 8'd1), 1);
        decode_ready = 1'b1;
        repeat (6) tick();

        // Branch to 40 while stalled with the skid full.
        decode_ready = 1'b0;
        tick();
        tick();
        branch(8'h40);
        decode_ready = 1'b1;
        check("br_valid_e0", instr_valid, 0);
        tick();
        check("br_valid_e1", instr_valid, 0);
        tick();
        check("br_valid_e2", instr_valid, 1);
        check("br_pcout", pc_out, 8'h40);
        check("br_instr", instr_out, 8'h1A);
        repeat (3) tick();

        // Branch to FE and wrap through 00.
        branch(8'hFE);
        check("wrap_pc_fe", pccounter, 8'hFE);
        tick();
        check("wrap_pc_ff", pccounter, 8'hFF);
        tick();
        check("wrap_pc_00", pccounter, 8'h00);
        check("wrap_out_fe", pc_out, 8'hFE);
        tick();
        check("wrap_out_ff", pc_out, 8'hFF);
        tick();
        check("wrap_out_00", pc_out, 8'h00);
        tick();
        check("wrap_out_01", pc_out, 8'h01);

        // Asynchronous reset between edges.
        #1;
        reset = 1'b1;
        flush_to(RESET_PC);
        #1;
        check("async_valid", instr_valid, 0);
        check("async_instr", instr_out, 0);
        check("async_pcout", pc_out, 0);
        check("async_pccounter", pccounter, RESET_PC);
        tick();
        tick();
        reset = 1'b0;
        startup_checks("restart");

        // Randomized back-pressure and branches.
        fired_before = n_fired;
        for (int i = 0; i < 400; i++) begin
            decode_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                branch(8'($urandom_range(0, 255)));
            end else begin
                tick();
            end
        end
        decode_ready = 1'b1;
        repeat (6) tick();
        check("random_progress", (n_fired - fired_before > 100), 1);

`ifdef FETCH_STALL_CNT_EN
        reset = 1'b1;
        flush_to(RESET_PC);
        tick();
        check("cnt_reset", stall_count, 16'h0000);
        reset = 1'b0;
        tick();
        tick();
        decode_ready = 1'b0;
        repeat (7) tick();
        check("cnt_seven", stall_count, 16'd7);
        repeat (70000) tick();
        check("cnt_saturate", stall_count, 16'hFFFF);
        decode_ready = 1'b1;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
